sc_pointarbiter: RTL and testbench
==================================

Name: sc_pointarbiter

Overview:
- Controller and arbiter for the team's 8-bit point counter (active-low upcount input, active-high reset input).
- Two scoring sources request point awards: amount plus level request, req/ack handshake. The block grants one source at a time, round-robin.
- Converts the granted amount into that many single-cycle upcount strobes.
- Keeps a shadow copy of the count, clamps the score at a target, raises a win flag, and sequences score clears.

Parameters:
- POINTARBITER_DATAWIDTH, 8, width of shadow count; equals the point counter's data width.
- POINTARBITER_AMOUNTWIDTH, 4, width of each requester's award amount.
- POINTARBITER_TARGET, 99, score at which counting stops and win asserts; must be < 2^DATAWIDTH.

Ports:
- SC_POINTARBITER_CLOCK_50 input 1 system clock; all logic on rising edge.
- SC_POINTARBITER_RESET_InLow input 1 asynchronous, active-low reset.
- SC_POINTARBITER_req_InBUS input 2 level requests; bit i from source i; held until ack.
- SC_POINTARBITER_amount0_InBUS input AMOUNTWIDTH award for source 0; stable while req[0]=1.
- SC_POINTARBITER_amount1_InBUS input AMOUNTWIDTH award for source 1; stable while req[1]=1.
- SC_POINTARBITER_clear_InLow input 1 clear-score request, active low, one cycle or longer.
- SC_POINTARBITER_ack_OutBUS output 2 one-cycle, one-hot completion pulse per source.
- SC_POINTARBITER_grant_OutBUS output 2 one-hot owner of the current transfer; 00 when idle.
- SC_POINTARBITER_upcount_OutLow output 1 drives counter upcount; 0 means increment this cycle.
- SC_POINTARBITER_counterReset_OutHigh output 1 drives counter reset; one-cycle pulse.
- SC_POINTARBITER_busy_OutHigh output 1 high whenever state is not IDLE.
- SC_POINTARBITER_win_OutHigh output 1 high while shadow == TARGET.

Behaviour:
- All outputs are registered.
- Reset (async, RESET_InLow=0):
  - state=IDLE, shadow=0, remaining=0, rr pointer favours source 0, clearPending=0.
  - ack=00, grant=00, upcount_OutLow=1, counterReset_OutHigh=0, busy=0, win=0.
  - Reset mid-transfer aborts it with no ack. The top level resets the counter from the same system reset.
- States: IDLE, COUNT, ACK, CLEAR.
- IDLE priority order:
  1. If clear_InLow=0 or clearPending=1 → CLEAR.
  2. Else if any req → arbitrate, latch grant and amount into remaining.
     - Next state is COUNT if amount≠0 and win=0; otherwise ACK.
  3. Else stay in IDLE.
- Arbitration:
  - One request pending → grant it.
  - Both pending → grant the source not granted last; update pointer on grant.
- COUNT:
  - upcount_OutLow=0 for exactly min(remaining, TARGET−shadow) consecutive cycles.
  - Each strobe cycle: shadow+1, remaining−1.
  - Leave COUNT when remaining hits 0 or shadow hits TARGET; excess points are discarded → ACK.
  - Latency: grant-cycle+1 to first strobe; N strobes occupy N cycles back-to-back.
- ACK: ack[grant]=1 for one cycle, grant cleared → IDLE. The requester drops req in the cycle after ack; IDLE re-samples then.
- CLEAR: counterReset_OutHigh=1 for one cycle; shadow=0, win=0, clearPending=0 → IDLE.
- clear_InLow=0 seen in COUNT/ACK: set clearPending; the transfer completes first.
- win: combinational compare registered each cycle. While win=1, requests are still granted and acked, with zero strobes.
- Shadow width DATAWIDTH, remaining width AMOUNTWIDTH; no wrap is possible because of the TARGET clamp.
- Amount 0: grant → ACK directly, no strobes.

Optional Feature:
- SC_POINTARBITER_FIXEDPRIORITY_EN defined: source 0 always wins simultaneous requests; rr pointer is not instantiated.
- Undefined: round-robin as above.

Decomposition:
- Package sc_pointarbiter_pkg holds:
  - state encoding localparams (IDLE/COUNT/ACK/CLEAR, 2 bits)
  - one-hot grant constants GRANT_NONE/GRANT_0/GRANT_1
- Sub-module sc_pointarbiter_rr: 2-way round-robin arbiter.
  - Inputs: req, grant-enable. Outputs: one-hot grant, pointer.
  - Macro-controlled fixed priority lives inside it.

Test Plan:
- Reset, then req[0]=1, amount0=3 → grant=01 next cycle; upcount_OutLow=0 for 3 consecutive cycles; ack=01 one cycle; shadow=3; busy falls.
- req=11 simultaneously, amount0=2, amount1=5 → source 0 served first (2 strobes, ack=01). Source 1 served next (5 strobes, ack=10), shadow=7. Repeat with both: source 1 first only when FIXEDPRIORITY undefined.
- shadow=97, req[1] amount1=6 → exactly 2 strobes, win=1, ack=10. A further req[0] amount=4 → ack with 0 strobes.
- clear_InLow=0 during the 3rd of 5 strobes → the remaining strobes finish and ack occurs. Then counterReset_OutHigh pulses one cycle, shadow=0, win=0.
- amount0=0 request → ack=01 two cycles after req, upcount_OutLow stays 1.
- Assert RESET_InLow=0 mid-COUNT → all outputs immediately at reset values; no ack; after release, a new request is served normally from source 0.

Source files
------------

// File: rtl/sc_pointarbiter_pkg.sv
// Shared types and constants for the point-counter arbiter/controller.
package sc_pointarbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_ACK   = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_0    = 2'b01;
  localparam logic [1:0] GRANT_1    = 2'b10;

endpackage

// File: rtl/sc_pointarbiter_rr.sv
// Two-way arbiter; round-robin by default, fixed priority (source 0 first)
// when SC_POINTARBITER_FIXEDPRIORITY_EN is defined.
module sc_pointarbiter_rr
  import sc_pointarbiter_pkg::*;
(
  input  logic       SC_POINTARBITER_CLOCK_50,
  input  logic       SC_POINTARBITER_RESET_InLow,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] grant,
  output logic       ptr
);

`ifdef SC_POINTARBITER_FIXEDPRIORITY_EN

  assign ptr = 1'b0;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    grant = GRANT_NONE;
    if (grant_en) begin
      if (req[0])      grant = GRANT_0;
      else if (req[1]) grant = GRANT_1;
    end
  end

`else

  logic ptr_q;

  assign ptr = ptr_q;

  always_comb begin
    grant = GRANT_NONE;
    if (grant_en) begin
      unique case (req)
        2'b01:   grant = GRANT_0;
        2'b10:   grant = GRANT_1;
        2'b11:   grant = ptr_q ? GRANT_1 : GRANT_0;
        default: grant = GRANT_NONE;
      endcase
    end
  end

  // Pointer names the favoured source: the one not granted last.
  always_ff @(posedge SC_POINTARBITER_CLOCK_50 or negedge SC_POINTARBITER_RESET_InLow) begin
    if (!SC_POINTARBITER_RESET_InLow) begin
      ptr_q <= 1'b0;
    end else if (grant_en && (req != 2'b00)) begin
      // NOTE: sequential state uses non-blocking assignments only.
      ptr_q <= (grant == GRANT_0);
    end
  end

`endif

endmodule

// File: rtl/sc_pointarbiter.sv
// Arbitrates two point-award sources onto the 8-bit point counter, clamps at
// TARGET and sequences clears. Macro: SC_POINTARBITER_FIXEDPRIORITY_EN.
module sc_pointarbiter
  import sc_pointarbiter_pkg::*;
#(
  parameter int POINTARBITER_DATAWIDTH   = 8,
  parameter int POINTARBITER_AMOUNTWIDTH = 4,
  parameter int POINTARBITER_TARGET      = 99
)(
  input  logic                                SC_POINTARBITER_CLOCK_50,
  input  logic                                SC_POINTARBITER_RESET_InLow,
  input  logic [1:0]                          SC_POINTARBITER_req_InBUS,
  input  logic [POINTARBITER_AMOUNTWIDTH-1:0] SC_POINTARBITER_amount0_InBUS,
  input  logic [POINTARBITER_AMOUNTWIDTH-1:0] SC_POINTARBITER_amount1_InBUS,
  input  logic                                SC_POINTARBITER_clear_InLow,
  output logic [1:0]                          SC_POINTARBITER_ack_OutBUS,
  output logic [1:0]                          SC_POINTARBITER_grant_OutBUS,
  output logic                                SC_POINTARBITER_upcount_OutLow,
  output logic                                SC_POINTARBITER_counterReset_OutHigh,
  output logic                                SC_POINTARBITER_busy_OutHigh,
  output logic                                SC_POINTARBITER_win_OutHigh
);

  localparam logic [POINTARBITER_DATAWIDTH-1:0] TARGET_VAL =
    POINTARBITER_DATAWIDTH'(POINTARBITER_TARGET);
  localparam logic [POINTARBITER_AMOUNTWIDTH-1:0] ONE_AMOUNT =
    POINTARBITER_AMOUNTWIDTH'(1);

  state_t                              state;
  logic [POINTARBITER_DATAWIDTH-1:0]   shadow;
  logic [POINTARBITER_AMOUNTWIDTH-1:0] remaining;
  logic                                clear_pending;

  logic [1:0]                          arb_grant;
  logic                                rr_ptr;
  logic                                grant_en;
  logic [POINTARBITER_AMOUNTWIDTH-1:0] arb_amount;
  logic [POINTARBITER_DATAWIDTH-1:0]   shadow_inc;
  logic                                at_target;

  // No new grant during the ack cycle: the requester still holds req then.
  assign grant_en   = (state == ST_IDLE) && (SC_POINTARBITER_ack_OutBUS == GRANT_NONE) &&
                      SC_POINTARBITER_clear_InLow && !clear_pending;
  assign arb_amount = (arb_grant == GRANT_1) ? SC_POINTARBITER_amount1_InBUS
                                             : SC_POINTARBITER_amount0_InBUS;
  assign shadow_inc = shadow + 1'b1;
  assign at_target  = (shadow == TARGET_VAL);

  sc_pointarbiter_rr u_rr (
    .SC_POINTARBITER_CLOCK_50    (SC_POINTARBITER_CLOCK_50),
    .SC_POINTARBITER_RESET_InLow (SC_POINTARBITER_RESET_InLow),
    .req                         (SC_POINTARBITER_req_InBUS),
    .grant_en                    (grant_en),
    .grant                       (arb_grant),
    .ptr                         (rr_ptr)
  );

  // Contested grants must go to the source the pointer favours.
  a_contested_grant : assert property (
    @(posedge SC_POINTARBITER_CLOCK_50) disable iff (!SC_POINTARBITER_RESET_InLow)
    (grant_en && SC_POINTARBITER_req_InBUS == 2'b11) |-> (arb_grant == (rr_ptr ? GRANT_1 : GRANT_0))
  );

  always_ff @(posedge SC_POINTARBITER_CLOCK_50 or negedge SC_POINTARBITER_RESET_InLow) begin
    if (!SC_POINTARBITER_RESET_InLow) begin
      state                                <= ST_IDLE;
      shadow                               <= '0;
      remaining                            <= '0;
      clear_pending                        <= 1'b0;
      SC_POINTARBITER_ack_OutBUS           <= GRANT_NONE;
      SC_POINTARBITER_grant_OutBUS         <= GRANT_NONE;
      SC_POINTARBITER_upcount_OutLow       <= 1'b1;
      SC_POINTARBITER_counterReset_OutHigh <= 1'b0;
      SC_POINTARBITER_busy_OutHigh         <= 1'b0;
      SC_POINTARBITER_win_OutHigh          <= 1'b0;
    end else begin
      // Pulse outputs default to their inactive level every cycle.
      SC_POINTARBITER_ack_OutBUS           <= GRANT_NONE;
      SC_POINTARBITER_upcount_OutLow       <= 1'b1;
      SC_POINTARBITER_counterReset_OutHigh <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (!SC_POINTARBITER_clear_InLow || clear_pending) begin
            state                        <= ST_CLEAR;
            SC_POINTARBITER_busy_OutHigh <= 1'b1;
          end else if (arb_grant != GRANT_NONE) begin
            SC_POINTARBITER_grant_OutBUS <= arb_grant;
            remaining                    <= arb_amount;
            SC_POINTARBITER_busy_OutHigh <= 1'b1;
            state <= ((arb_amount != '0) && !SC_POINTARBITER_win_OutHigh) ? ST_COUNT : ST_ACK;
          end
        end

        ST_COUNT: begin
          if (!SC_POINTARBITER_clear_InLow) clear_pending <= 1'b1;
          if ((remaining != '0) && !at_target) begin
            SC_POINTARBITER_upcount_OutLow <= 1'b0;
            shadow                         <= shadow_inc;
            remaining                      <= remaining - ONE_AMOUNT;
            SC_POINTARBITER_win_OutHigh    <= (shadow_inc == TARGET_VAL);
            if ((remaining == ONE_AMOUNT) || (shadow_inc == TARGET_VAL)) state <= ST_ACK;
          end else begin
            state <= ST_ACK;
          end
        end

        ST_ACK: begin
          if (!SC_POINTARBITER_clear_InLow) clear_pending <= 1'b1;
          // Points left over after the clamp are discarded here.
          SC_POINTARBITER_ack_OutBUS   <= SC_POINTARBITER_grant_OutBUS;
          SC_POINTARBITER_grant_OutBUS <= GRANT_NONE;
          remaining                    <= '0;
          SC_POINTARBITER_busy_OutHigh <= 1'b0;
          state                        <= ST_IDLE;
        end

        ST_CLEAR: begin
          SC_POINTARBITER_counterReset_OutHigh <= 1'b1;
          shadow                               <= '0;
          SC_POINTARBITER_win_OutHigh          <= 1'b0;
          clear_pending                        <= 1'b0;
          SC_POINTARBITER_busy_OutHigh         <= 1'b0;
          state                                <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_pointarbiter.sv
// Directed self-checking bench for sc_pointarbiter with a small score model.
module tb_sc_pointarbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [3:0] amount0;
  logic [3:0] amount1;
  logic       clear_n;
  logic [1:0] ack;
  logic [1:0] grant;
  logic       upcount_n;
  logic       cnt_rst;
  logic       busy;
  logic       win;

  int checks   = 0;
  int errors   = 0;
  int shadow_m = 0;
  int lat;
  int e0, e1;

  sc_pointarbiter dut (
    .SC_POINTARBITER_CLOCK_50             (clk),
    .SC_POINTARBITER_RESET_InLow          (rst_n),
    .SC_POINTARBITER_req_InBUS            (req),
    .SC_POINTARBITER_amount0_InBUS        (amount0),
    .SC_POINTARBITER_amount1_InBUS        (amount1),
    .SC_POINTARBITER_clear_InLow          (clear_n),
    .SC_POINTARBITER_ack_OutBUS           (ack),
    .SC_POINTARBITER_grant_OutBUS         (grant),
    .SC_POINTARBITER_upcount_OutLow       (upcount_n),
    .SC_POINTARBITER_counterReset_OutHigh (cnt_rst),
    .SC_POINTARBITER_busy_OutHigh         (busy),
    .SC_POINTARBITER_win_OutHigh          (win)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ack"},   32'(ack),       32'h0);
    check({tag, "_grant"}, 32'(grant),     32'h0);
    check({tag, "_upcnt"}, 32'(upcount_n), 32'h1);
    check({tag, "_crst"},  32'(cnt_rst),   32'h0);
    check({tag, "_busy"},  32'(busy),      32'h0);
  endtask

  function automatic int exp_strobes(input int amt);
    if (shadow_m >= 99) return 0;
    return (amt < 99 - shadow_m) ? amt : 99 - shadow_m;
  endfunction

  // Follows one transfer from request to ack, then drops that request.
  task automatic observe(input string tag, input int src, input int exp_n,
                         input int clear_at, output int latency);
    int   n     = 0;
    int   first = 0;
    int   last  = 0;
    bit   seen  = 0;
    bit   done  = 0;
    logic [1:0] oh;
    oh = (src == 0) ? 2'b01 : 2'b10;
    latency = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      latency++;
      if (grant != 2'b00) seen = 1;
    end
    check({tag, "_grant"}, 32'(grant), 32'(oh));
    check({tag, "_busy"},  32'(busy),  32'h1);
    for (int i = 0; i < 40 && seen && !done; i++) begin
      tick();
      latency++;
      if (!clear_n) clear_n = 1'b1;
      if (i == 0 && exp_n > 0) check({tag, "_first"}, 32'(upcount_n), 32'h0);
      if (ack != 2'b00) done = 1;
      if (upcount_n == 1'b0) begin
        if (n == 0) first = i;
        last = i;
        n++;
        if (n == clear_at) clear_n = 1'b0;
      end
    end
    check({tag, "_done"},    32'(done),  32'h1);
    check({tag, "_ack"},     32'(ack),   32'(oh));
    check({tag, "_ackgnt"},  32'(grant), 32'h0);
    check({tag, "_ackbusy"}, 32'(busy),  32'h0);
    check({tag, "_strobes"}, 32'(n),     32'(exp_n));
    check({tag, "_contig"},  (n == 0) ? 32'h0 : 32'(last - first + 1), 32'(n));
    tick();
    req[src] = 1'b0;
  endtask

  task automatic serve(input string tag, input int src, input int amt);
    int e;
    int l;
    if (src == 0) amount0 = 4'(amt);
    else          amount1 = 4'(amt);
    req[src] = 1'b1;
    e = exp_strobes(amt);
    observe(tag, src, e, 0, l);
    shadow_m += e;
    check({tag, "_win"}, 32'(win), 32'(shadow_m == 99));
  endtask

  task automatic pulse_reset;
    rst_n = 1'b0;
    #1;
    shadow_m = 0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    req     = 2'b00;
    amount0 = '0;
    amount1 = '0;
    clear_n = 1'b1;
    tick();
    tick();
    check_idle("rst");
    check("rst_win", 32'(win), 32'h0);
    rst_n = 1'b1;
    tick();

    // Single source, three points.
    serve("t1", 0, 3);

    // Simultaneous requests from a fresh pointer: source 0 first.
    pulse_reset();
    amount0 = 4'd2;
    amount1 = 4'd5;
    req     = 2'b11;
    e0 = exp_strobes(2);
    observe("t2a", 0, e0, 0, lat);
    shadow_m += e0;
    e1 = exp_strobes(5);
    observe("t2b", 1, e1, 0, lat);
    shadow_m += e1;
    check("t2_win", 32'(win), 32'h0);

    // Source 0 served alone, then a contested request.
    serve("t3a", 0, 1);
    amount0 = 4'd1;
    amount1 = 4'd1;
    req     = 2'b11;
`ifdef SC_POINTARBITER_FIXEDPRIORITY_EN
    observe("t3b", 0, 1, 0, lat);
    observe("t3c", 1, 1, 0, lat);
`else
    observe("t3b", 1, 1, 0, lat);
    observe("t3c", 0, 1, 0, lat);
`endif
    shadow_m += 2;

    // Clear arrives during the third of five strobes; transfer completes first.
    amount0 = 4'd5;
    req[0]  = 1'b1;
    observe("t4", 0, exp_strobes(5), 3, lat);
    tick();
    check("t4_crst1", 32'(cnt_rst), 32'h1);
    check("t4_win",   32'(win),     32'h0);
    tick();
    check("t4_crst0", 32'(cnt_rst), 32'h0);
    check("t4_busy",  32'(busy),    32'h0);
    shadow_m = 0;

    // Build the score up to 97.
    for (int k = 0; k < 6; k++) serve("build", k % 2, 15);
    serve("build7", 0, 7);

    // Clamp at target: only two of six points counted.
    serve("t5", 1, 6);
    check("t5_model", 32'(shadow_m), 32'd99);
    serve("t6", 0, 4);

    // Clear from IDLE drops win.
    clear_n = 1'b0;
    tick();
    clear_n = 1'b1;
    check("t7_busy",  32'(busy),    32'h1);
    check("t7_crst0", 32'(cnt_rst), 32'h0);
    tick();
    check("t7_crst1", 32'(cnt_rst), 32'h1);
    check("t7_win",   32'(win),     32'h0);
    tick();
    check("t7_crst2", 32'(cnt_rst), 32'h0);
    shadow_m = 0;

    // Zero amount: ack two cycles after request, no strobes.
    amount0 = 4'd0;
    req[0]  = 1'b1;
    observe("t8", 0, 0, 0, lat);
    check("t8_lat", 32'(lat), 32'd2);

    // Reset in the middle of a count.
    amount0 = 4'd8;
    req[0]  = 1'b1;
    tick();
    check("t9_grant", 32'(grant), 32'h1);
    tick();
    tick();
    check("t9_strobe", 32'(upcount_n), 32'h0);
    rst_n = 1'b0;
    #1;
    req = 2'b00;
    check_idle("t9_rst");
    check("t9_win", 32'(win), 32'h0);
    shadow_m = 0;
    tick();
    check("t9_noack", 32'(ack), 32'h0);
    rst_n = 1'b1;
    tick();
    amount0 = 4'd2;
    amount1 = 4'd3;
    req     = 2'b11;
    observe("t9a", 0, 2, 0, lat);
    observe("t9b", 1, 3, 0, lat);
    shadow_m += 5;
    check("t9_win2", 32'(win), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
